// File: rtl/fp_pkg.sv
// Shared widths, field positions and FSM states for the integer <-> simplified-FP converters.
// FP word layout is {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}, value 0.frac * 2^exp.
package fp_pkg;

  localparam int FRAC_W   = 8;
  localparam int EXP_W    = 4;
  localparam int FP_W     = 1 + EXP_W + FRAC_W;
  localparam int INT_W    = FRAC_W;
  localparam int MAG_W    = INT_W - 1;

  localparam int SIGN_POS = FP_W - 1;
  localparam int EXP_MSB  = FP_W - 2;
  localparam int EXP_LSB  = FRAC_W;
  localparam int FRAC_MSB = FRAC_W - 1;
  localparam int FRAC_LSB = 0;

  // Exponent before any normalising shift: the raw magnitude sits as 0.0mmmmmmm * 2^FRAC_W.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FRAC_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/int_to_fp_if.sv
// Handshake bundle between an integer source, the converter and an FP consumer.
// slave = converter side, master = source/consumer side.
interface int_to_fp_if;
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] int_in;
  logic             out_valid;
  logic             out_ready;
  logic [FP_W-1:0]  fp_out;
  logic             busy;

  modport master (
    output in_valid, int_in, out_ready,
    input  in_ready, out_valid, fp_out, busy
  );

  modport slave (
    input  in_valid, int_in, out_ready,
    output in_ready, out_valid, fp_out, busy
  );

endinterface

// File: rtl/int_to_fp_lzc7.sv
// 7-bit leading-zero counter, purely combinational; returns 7 for an all-zero input.
module lzc7 (
  input  logic [6:0] i_dat,
  output logic [2:0] o_cnt
);

  logic [2:0] w_cnt;

  // Ascending scan so the most significant set bit is the last (winning) assignment.
  always_comb begin
    w_cnt = 3'd7;
    for (int i = 0; i < 7; i++) begin
      if (i_dat[i]) begin
        w_cnt = 3'(6 - i);
      end
    end
  end

  assign o_cnt = w_cnt;

endmodule

// File: rtl/int_to_fp.sv
// Sign-magnitude int -> {sign,exp,frac} FP; iterative 1-bit/clk normalisation, result held until out_ready.
// INT_TO_FP_FASTNORM_EN: leading-zero count normalises at the accept edge, NORM is never entered.
module int_to_fp
  import fp_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  int_to_fp_if.slave bus
);

  conv_state_t      r_state;
  conv_state_t      w_next;
  logic [FP_W-1:0]  r_fp_out;
  logic [FP_W-1:0]  w_result;
  logic             w_load;

  logic [MAG_W-1:0] w_mag;
  logic             w_sign_in;
  logic             w_mag_zero;
  logic             w_accept;

  assign w_mag      = bus.int_in[MAG_W-1:0];
  assign w_sign_in  = bus.int_in[INT_W-1];
  assign w_mag_zero = (w_mag == '0);
  assign w_accept   = (r_state == IDLE) && bus.in_valid;

`ifdef INT_TO_FP_FASTNORM_EN
  logic [2:0]        w_lz;
  logic [2:0]        w_shift;
  logic [FRAC_W-1:0] w_norm_frac;
  logic [EXP_W-1:0]  w_norm_exp;

  lzc7 u_lzc (
    .i_dat (w_mag),
    .o_cnt (w_lz)
  );

  // A zero magnitude wraps w_shift, but zero takes its own canonical path below.
  assign w_shift     = w_lz + 3'd1;
  assign w_norm_frac = {1'b0, w_mag} << w_shift;
  assign w_norm_exp  = EXP_W'(MAG_W) - EXP_W'(w_lz);
`else
  logic              r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [FRAC_W-1:0] r_frac;
  logic [FRAC_W-1:0] w_frac_shl;
  logic [EXP_W-1:0]  w_exp_dec;

  assign w_frac_shl = r_frac << 1;
  assign w_exp_dec  = r_exp - 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_frac <= '0;
    end else if (w_accept) begin
      if (w_mag_zero) begin
        r_sign <= 1'b0;
        r_exp  <= '0;
        r_frac <= '0;
      end else begin
        r_sign <= w_sign_in;
        r_exp  <= EXP_INIT;
        r_frac <= {1'b0, w_mag};
      end
    end else if (r_state == NORM) begin
      r_frac <= w_frac_shl;
      r_exp  <= w_exp_dec;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the FP word latched on every entry into DONE.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_result = r_fp_out;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (w_mag_zero) begin
            w_next   = DONE;
            w_load   = 1'b1;
            w_result = '0;
          end else begin
`ifdef INT_TO_FP_FASTNORM_EN
            w_next                      = DONE;
            w_load                      = 1'b1;
            w_result[SIGN_POS]          = w_sign_in;
            w_result[EXP_MSB:EXP_LSB]   = w_norm_exp;
            w_result[FRAC_MSB:FRAC_LSB] = w_norm_frac;
`else
            w_next = NORM;
`endif
          end
        end
      end
      NORM: begin
`ifdef INT_TO_FP_FASTNORM_EN
        w_next = IDLE;
`else
        if (r_frac[FRAC_W-2]) begin
          w_next                      = DONE;
          w_load                      = 1'b1;
          w_result[SIGN_POS]          = r_sign;
          w_result[EXP_MSB:EXP_LSB]   = w_exp_dec;
          w_result[FRAC_MSB:FRAC_LSB] = w_frac_shl;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fp_out <= '0;
    end else if (w_load) begin
      r_fp_out <= w_result;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == NORM);
  assign bus.fp_out    = r_fp_out;

endmodule
